// File: rtl/shift_seq.sv
// Multi-bit logical shifter that iterates an external 1-bit registered shift unit.
// Accepts one command at a time, issues one shift per ISSUE/WAIT pair, then holds the result.
module shift_seq #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_dir,
  input  logic [WIDTH-1:0] req_data,
  input  logic [AMT_W-1:0] req_amt,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic             su_en,
  output logic [3:0]       su_fun,
  output logic [WIDTH-1:0] su_a,
  input  logic [WIDTH-1:0] su_result,
  input  logic             su_flag
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_work;
  logic [AMT_W-1:0] r_cnt;
  logic             r_dir, r_err;
  logic             w_zero, w_sat, w_last;

  assign w_zero = (req_amt == '0);
  assign w_sat  = (32'(req_amt) >= 32'(WIDTH));
  assign w_last = (r_cnt == AMT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    su_en      = 1'b0;
    su_fun     = 4'b0000;
    su_a       = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = (w_zero || w_sat) ? DONE : ISSUE;
      end
      ISSUE: begin
        su_en  = 1'b1;
        su_a   = r_work;
        su_fun = r_dir ? 4'b1101 : 4'b1100;
        w_next = WAIT;
      end
      WAIT:    w_next = (!su_flag || w_last) ? DONE : ISSUE;
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Response registers only change on entry to DONE, so they hold through the stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_work    <= '0;
      r_cnt     <= '0;
      r_dir     <= 1'b0;
      r_err     <= 1'b0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_work <= req_data;
          r_dir  <= req_dir;
          r_cnt  <= req_amt;
          r_err  <= 1'b0;
          if (w_zero) begin
            resp_data <= req_data;
            resp_err  <= 1'b0;
          end else if (w_sat) begin
            resp_data <= '0;
            resp_err  <= 1'b0;
          end
        end
        WAIT: if (su_flag) begin
          r_work <= su_result;
          r_cnt  <= r_cnt - AMT_W'(1);
          if (w_last) begin
            resp_data <= su_result;
            resp_err  <= r_err;
          end
        end else begin
          // Shift unit reported a no-op: stop early with the last good value.
          r_err     <= 1'b1;
          resp_data <= r_work;
          resp_err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq with a behavioural 1-bit shift unit and a vector table.
module tb_shift_seq;
  localparam int WIDTH = 16;
  localparam int AMT_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0, req_dir = 1'b0, resp_ready = 1'b0;
  logic [WIDTH-1:0] req_data = '0;
  logic [AMT_W-1:0] req_amt = '0;
  logic             req_ready, resp_valid, resp_err, su_en;
  logic [WIDTH-1:0] resp_data, su_a;
  logic [3:0]       su_fun;
  logic [WIDTH-1:0] su_result = '0;
  logic             su_flag = 1'b0;

  shift_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_data(req_data), .req_amt(req_amt),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .su_en(su_en), .su_fun(su_fun), .su_a(su_a),
    .su_result(su_result), .su_flag(su_flag)
  );

  always #5 clk = ~clk;

  // Shift unit model plus protocol monitors on the su_* outputs.
  int       su_pulses = 0, kill_at = -1;
  int       bad_fun = 0, bad_alt = 0, bad_idle = 0;
  logic     prev_en = 1'b0;
  logic [3:0] exp_fun = 4'b0000;

  always @(posedge clk) begin
    prev_en <= su_en;
    if (su_en) begin
      su_pulses <= su_pulses + 1;
      su_result <= (su_fun == 4'b1101) ? (su_a << 1) : (su_a >> 1);
      su_flag   <= ((su_pulses + 1) != kill_at);
      if (su_fun != exp_fun) bad_fun <= bad_fun + 1;
      if (prev_en) bad_alt <= bad_alt + 1;
    end else begin
      su_flag <= 1'b0;
      if (su_fun != 4'b0000 || su_a != '0) bad_idle <= bad_idle + 1;
    end
  end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic             dir;
    logic [WIDTH-1:0] data;
    logic [AMT_W-1:0] amt;
    int               kill;
    logic [WIDTH-1:0] exp_data;
    logic             exp_err;
    int               exp_lat;
    int               exp_pulses;
  } vec_t;

  // Accept, wait for resp_valid, check, then complete the handshake.
  task automatic run_cmd(input vec_t v, input string tag);
    int lat, p0;
    @(negedge clk);
    chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    p0      = su_pulses;
    kill_at = (v.kill > 0) ? (p0 + v.kill) : -1;
    exp_fun = v.dir ? 4'b1101 : 4'b1100;
    req_valid = 1'b1; req_dir = v.dir; req_data = v.data; req_amt = v.amt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " resp_data"}, 32'(resp_data), 32'(v.exp_data));
    chk({tag, " resp_err"}, 32'(resp_err), 32'(v.exp_err));
    chk({tag, " su_en pulses"}, 32'(su_pulses - p0), 32'(v.exp_pulses));
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, " idle after handshake"}, {30'd0, req_ready, resp_valid}, 32'h2);
  endtask

  vec_t tbl[10];
  vec_t v;

  initial begin
    tbl[0] = '{1'b1, 16'h0001,  5'd4, 0, 16'h0010, 1'b0,  9,  4};
    tbl[1] = '{1'b0, 16'h8000, 5'd15, 0, 16'h0001, 1'b0, 31, 15};
    tbl[2] = '{1'b0, 16'hA5A5,  5'd0, 0, 16'hA5A5, 1'b0,  1,  0};
    tbl[3] = '{1'b1, 16'hA5A5, 5'd20, 0, 16'h0000, 1'b0,  1,  0};
    tbl[4] = '{1'b0, 16'hF0F0,  5'd4, 0, 16'h0F0F, 1'b0,  9,  4};
    tbl[5] = '{1'b1, 16'h8001,  5'd1, 0, 16'h0002, 1'b0,  3,  1};
    tbl[6] = '{1'b1, 16'h1234, 5'd16, 0, 16'h0000, 1'b0,  1,  0};
    tbl[7] = '{1'b0, 16'h1234, 5'd31, 0, 16'h0000, 1'b0,  1,  0};
    tbl[8] = '{1'b1, 16'hFFFF, 5'd15, 0, 16'h8000, 1'b0, 31, 15};
    tbl[9] = '{1'b0, 16'h00FF,  5'd3, 0, 16'h001F, 1'b0,  7,  3};

    #12;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_data/err", {15'd0, resp_err, resp_data}, 32'd0);
    chk("reset su_en/fun/a", {11'd0, su_en, su_fun, su_a}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

    // Shift unit no-op on the second WAIT ends the command with the error bit.
    v = '{1'b1, 16'h0003, 5'd5, 2, 16'h0006, 1'b1, 5, 2};
    run_cmd(v, "noflag");
    run_cmd(tbl[0], "err clears");

    // Response stall with a competing request.
    begin
      int p0;
      v = '{1'b1, 16'h0001, 5'd2, 0, 16'h0004, 1'b0, 5, 2};
      @(negedge clk);
      exp_fun = 4'b1101; kill_at = -1;
      req_valid = 1'b1; req_dir = 1'b1; req_data = v.data; req_amt = v.amt;
      @(posedge clk); #1;
      req_data = 16'h7777; req_amt = 5'd3;
      for (int c = 0; c < 4; c++) begin @(posedge clk); #1; end
      chk("stall first valid", 32'(resp_valid), 32'd1);
      p0 = su_pulses;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        chk("stall valid/ready", {30'd0, resp_valid, req_ready}, 32'h2);
        chk("stall data", 32'(resp_data), 32'h0004);
      end
      @(negedge clk);
      resp_ready = 1'b1; req_valid = 1'b0;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("stall idle after hs", {30'd0, req_ready, resp_valid}, 32'h2);
      @(posedge clk); #1;
      chk("stall no second accept", 32'(su_pulses - p0), 32'd0);
      chk("stall still idle", 32'(req_ready), 32'd1);
    end

    // Reset during WAIT abandons the command.
    @(negedge clk);
    exp_fun = 4'b1101; kill_at = -1;
    req_valid = 1'b1; req_dir = 1'b1; req_data = 16'h0001; req_amt = 5'd8;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst-mid ISSUE su_en", 32'(su_en), 32'd1);
    @(posedge clk); #1;
    chk("rst-mid WAIT su_en", 32'(su_en), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst-mid req_ready", 32'(req_ready), 32'd1);
    chk("rst-mid resp", {15'd0, resp_valid, resp_data}, 32'd0);
    chk("rst-mid resp_err/su", {11'd0, resp_err, su_fun, su_a}, 32'd0);
    @(posedge clk); #1;
    chk("rst-held resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post-rst idle", {30'd0, req_ready, resp_valid}, 32'h2);
    v = '{1'b1, 16'h0001, 5'd8, 0, 16'h0100, 1'b0, 17, 8};
    run_cmd(v, "post-rst");

    chk("su_fun on pulses", 32'(bad_fun), 32'd0);
    chk("su_en never back-to-back", 32'(bad_alt), 32'd0);
    chk("su outputs zero when idle", 32'(bad_idle), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
